// File: rtl/exe_seq_pkg.sv
// exe_seq_pkg: widths, instruction field offsets, FSM states and NOP word for the EXE sequencer.
package exe_seq_pkg;
    localparam int DATA_W   = 6;
    localparam int RADDR_W  = 4;
    localparam int OPER_W   = 3;
    localparam int DEPTH    = 16;
    localparam int AW       = $clog2(DEPTH);
    localparam int INSTR_W  = OPER_W + 1 + 3 * RADDR_W + DATA_W;
    localparam int DATA_LSB = 0;
    localparam int REG2_LSB = DATA_LSB + DATA_W;
    localparam int REG1_LSB = REG2_LSB + RADDR_W;
    localparam int REG0_LSB = REG1_LSB + RADDR_W;
    localparam int IMM_BIT  = REG0_LSB + RADDR_W;
    localparam int OPER_LSB = IMM_BIT + 1;
    localparam logic [INSTR_W-1:0] NOP = '0;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/exe_seq_prog_mem.sv
// exe_seq_prog_mem: DEPTH x INSTR_W program buffer, synchronous write, asynchronous read, no reset.
module exe_seq_prog_mem
    import exe_seq_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);
    logic [INSTR_W-1:0] mem_q [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end
    assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/exe_seq.sv
// exe_seq: issues a loaded program to EXE, one word per HOLD_CYC cycles.
// Optional halt on EXE flag feedback is enabled by defining EXE_SEQ_FLAG_HALT_EN.
module exe_seq
    import exe_seq_pkg::*;
#(
    parameter int HOLD_CYC      = 1,
    parameter int HALT_FLAG_BIT = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [AW-1:0]             i_wr_addr,
    input  logic [INSTR_W-1:0]        i_wr_instr,
    input  logic                      i_start,
    input  logic [AW:0]               i_len,
    input  logic                      i_abort,
    input  logic [3:0]                i_flag,
    output logic [OPER_W-1:0]         o_oper,
    output logic                      o_imm,
    output logic [RADDR_W-1:0]        o_reg0,
    output logic [RADDR_W-1:0]        o_reg1,
    output logic [RADDR_W-1:0]        o_reg2,
    output logic signed [DATA_W-1:0]  o_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_halted,
    output logic [AW-1:0]             o_pc
);
    localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d, last_q, last_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               halted_q, halted_d;
    logic               halt_hit;
    logic [INSTR_W-1:0] rd_instr, issue;

    // Writes are blocked only while running, so buffer contents are stable during a run.
    exe_seq_prog_mem u_mem (
        .i_clk   (i_clk),
        .i_we    (i_wr_en && state_q != RUN),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_instr),
        .i_raddr (pc_q),
        .o_rdata (rd_instr)
    );

`ifdef EXE_SEQ_FLAG_HALT_EN
    assign halt_hit = i_flag[HALT_FLAG_BIT] && !(HOLD_CYC == 1 && pc_q == '0);
`else
    logic unused_flag;
    assign unused_flag = ^i_flag;
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        last_d   = last_q;
        hold_d   = hold_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: if (i_start && i_len != '0) begin
                state_d  = RUN;
                pc_d     = '0;
                hold_d   = '0;
                halted_d = 1'b0;
                last_d   = i_len > (AW+1)'(DEPTH) ? AW'(DEPTH - 1) : AW'(i_len - (AW+1)'(1));
            end
            RUN: if (i_abort) begin
                state_d  = IDLE;
                halted_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                if (halt_hit) begin
                    state_d  = IDLE;
                    halted_d = 1'b1;
                end else if (pc_q == last_q) state_d = DONE;
                else pc_d = pc_q + 1'b1;
            end else hold_d = hold_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            hold_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            halted_q <= halted_d;
        end
    end

    // Issue word comes straight from the registered buffer, so a same-edge write to buf[0] is seen.
    assign issue    = state_q == RUN ? rd_instr : NOP;
    assign o_oper   = issue[OPER_LSB +: OPER_W];
    assign o_imm    = issue[IMM_BIT];
    assign o_reg0   = issue[REG0_LSB +: RADDR_W];
    assign o_reg1   = issue[REG1_LSB +: RADDR_W];
    assign o_reg2   = issue[REG2_LSB +: RADDR_W];
    assign o_data   = issue[DATA_LSB +: DATA_W];
    assign o_busy   = state_q == RUN;
    assign o_done   = state_q == DONE;
    assign o_halted = halted_q;
    assign o_pc     = pc_q;
endmodule

// File: tb/tb_exe_seq.sv
// tb_exe_seq: directed self-checking bench for exe_seq (HOLD_CYC=1 and HOLD_CYC=5 instances).
module tb_exe_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, start = 1'b0, start5 = 1'b0, abort = 1'b0;
    logic [3:0]  wr_addr = '0, flag = '0;
    logic [21:0] wr_instr = '0;
    logic [4:0]  len = '0;
    logic [2:0]  oper, oper5;
    logic        imm, imm5, busy, busy5, done, done5, halted, halted5;
    logic [3:0]  r0, r1, r2, r0_5, r1_5, r2_5, pc, pc5;
    logic signed [5:0] data, data5;
    logic [21:0] prog [16];
    int tests = 0, fails = 0;

    wire [28:0] obs  = {busy, done, halted, pc, oper, imm, r0, r1, r2, data};
    wire [28:0] obs5 = {busy5, done5, halted5, pc5, oper5, imm5, r0_5, r1_5, r2_5, data5};

    always #5 clk = ~clk;

    exe_seq #(.HOLD_CYC(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_instr(wr_instr),
        .i_start(start), .i_len(len), .i_abort(abort), .i_flag(flag),
        .o_oper(oper), .o_imm(imm), .o_reg0(r0), .o_reg1(r1), .o_reg2(r2), .o_data(data),
        .o_busy(busy), .o_done(done), .o_halted(halted), .o_pc(pc)
    );

    exe_seq #(.HOLD_CYC(5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_instr(wr_instr),
        .i_start(start5), .i_len(len), .i_abort(abort), .i_flag(flag),
        .o_oper(oper5), .o_imm(imm5), .o_reg0(r0_5), .o_reg1(r1_5), .o_reg2(r2_5), .o_data(data5),
        .o_busy(busy5), .o_done(done5), .o_halted(halted5), .o_pc(pc5)
    );

    function automatic logic [28:0] ex(input logic b, d, h, input logic [3:0] p, input logic [21:0] w);
        return {b, d, h, p, w};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input logic [21:0] w);
        wr_en = 1'b1; wr_addr = 4'(a); wr_instr = w;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        tick; tick;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL reset_dut: got %h want 0", obs); end
        tests++;
        if (obs5 !== '0) begin fails++; $display("FAIL reset_dut5: got %h want 0", obs5); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_load;
        prog[0] = {3'd1, 1'b1, 4'd1, 4'd0, 4'd0, 6'd2};
        prog[1] = {3'd1, 1'b1, 4'd2, 4'd0, 4'd0, 6'd5};
        prog[2] = {3'd2, 1'b0, 4'd3, 4'd1, 4'd2, 6'd0};
        for (int i = 3; i < 16; i++) prog[i] = {3'd4, 1'b0, i[3:0], 4'd1, 4'd2, 6'(i * 3)};
        for (int i = 0; i < 16; i++) write(i, prog[i]);
    endtask

    task automatic test_basic;
        logic [28:0] e;
        start = 1'b1; len = 5'd3;
        tick;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e = k < 3 ? ex(1, 0, 0, 4'(k), prog[k]) : ex(0, k == 3, 0, 4'd2, '0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL basic_c%0d: got %h want %h", k + 1, obs, e); end
            tick;
        end
    endtask

    task automatic test_write_start;
        logic [21:0] nw = 22'h2A5A5;
        wr_en = 1'b1; wr_addr = 4'd0; wr_instr = nw; start = 1'b1; len = 5'd1;
        tick;
        wr_en = 1'b0; start = 1'b0;
        tests++;
        if (obs !== ex(1, 0, 0, 0, nw)) begin fails++; $display("FAIL write_start: got %h want %h", obs, ex(1, 0, 0, 0, nw)); end
        tick; tick;
        write(0, prog[0]);
    endtask

    task automatic test_hold5;
        logic [28:0] e;
        start5 = 1'b1; len = 5'd2;
        tick;
        start5 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            e = k < 5 ? ex(1, 0, 0, 0, prog[0]) : k < 10 ? ex(1, 0, 0, 1, prog[1]) : ex(0, k == 10, 0, 1, '0);
            tests++;
            if (obs5 !== e) begin fails++; $display("FAIL hold5_c%0d: got %h want %h", k + 1, obs5, e); end
            tick;
        end
    endtask

    task automatic test_len_bounds;
        int cnt = 0;
        start = 1'b1; len = 5'd0;
        tick;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL len0_busy: got %b want 0", busy); end
        start = 1'b1; len = 5'd20;
        tick;
        start = 1'b0;
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            if (busy) cnt++;
            tick;
        end
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL len20_done: got %b want 1", done); end
        tests++;
        if (cnt != 16) begin fails++; $display("FAIL len20_count: got %0d want 16", cnt); end
        tests++;
        if (pc !== 4'd15) begin fails++; $display("FAIL len20_pc: got %0d want 15", pc); end
        tick;
    endtask

    task automatic test_abort;
        start = 1'b1; len = 5'd4;
        tick;
        start = 1'b0;
        tick;
        tests++;
        if (obs !== ex(1, 0, 0, 1, prog[1])) begin fails++; $display("FAIL abort_pre: got %h want %h", obs, ex(1, 0, 0, 1, prog[1])); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tests++;
        if (obs !== ex(0, 0, 1, 1, '0)) begin fails++; $display("FAIL abort_nop: got %h want %h", obs, ex(0, 0, 1, 1, '0)); end
        tick;
        tests++;
        if (obs !== ex(0, 0, 1, 1, '0)) begin fails++; $display("FAIL abort_nodone: got %h want %h", obs, ex(0, 0, 1, 1, '0)); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tests++;
        if (obs !== ex(0, 0, 1, 1, '0)) begin fails++; $display("FAIL abort_idle: got %h want %h", obs, ex(0, 0, 1, 1, '0)); end
        start = 1'b1; len = 5'd1;
        tick;
        start = 1'b0;
        tests++;
        if (obs !== ex(1, 0, 0, 0, prog[0])) begin fails++; $display("FAIL restart_clear: got %h want %h", obs, ex(1, 0, 0, 0, prog[0])); end
        tick;
        tests++;
        if (obs !== ex(0, 1, 0, 0, '0)) begin fails++; $display("FAIL restart_done: got %h want %h", obs, ex(0, 1, 0, 0, '0)); end
        tick;
    endtask

    task automatic test_ignored;
        logic [28:0] e;
        start = 1'b1; len = 5'd4;
        tick;
        wr_en = 1'b1; wr_addr = 4'd3; wr_instr = ~prog[3]; len = 5'd1;
        tick;
        wr_en = 1'b0; start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            e = k < 4 ? ex(1, 0, 0, 4'(k), prog[k]) : ex(0, 1, 0, 3, '0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL ignored_c%0d: got %h want %h", k, obs, e); end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1; len = 5'd4;
        tick;
        start = 1'b0;
        tick;
        #1 rst = 1'b1;
        #1;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL rst_async: got %h want 0", obs); end
        #1 rst = 1'b0;
        tick;
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL rst_idle: got %h want 0", obs); end
        start = 1'b1; len = 5'd1;
        tick;
        start = 1'b0;
        tests++;
        if (obs !== ex(1, 0, 0, 0, prog[0])) begin fails++; $display("FAIL rst_mem_kept: got %h want %h", obs, ex(1, 0, 0, 0, prog[0])); end
        tick; tick;
    endtask

    task automatic test_flag;
        logic [28:0] e;
        start = 1'b1; len = 5'd4;
        tick;
        start = 1'b0;
        tick;
        flag = 4'b0001;
        tick;
        flag = 4'b0000;
`ifdef EXE_SEQ_FLAG_HALT_EN
        e = ex(0, 0, 1, 1, '0);
`else
        e = ex(1, 0, 0, 2, prog[2]);
`endif
        tests++;
        if (obs !== e) begin fails++; $display("FAIL flag_halt: got %h want %h", obs, e); end
        tick; tick; tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_load;
        test_basic;
        test_write_start;
        test_hold5;
        test_len_bounds;
        test_abort;
        test_ignored;
        test_reset_mid;
        test_flag;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
